// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over separate
// instruction and data request/ack ports, halting permanently on an illegal instruction.
module multicycle_core #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned IMEM_AW = 8,
   parameter int unsigned DMEM_AW = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [31:0]        dmem_wdata,
   input  logic               dmem_ack,
   input  logic [31:0]        dmem_rdata,
   output logic [PC_W-1:0]    pc,
   output logic               retire,
   output logic               halted
);

   localparam logic [5:0] OpR    = 6'h00;
   localparam logic [5:0] OpLw   = 6'h23;
   localparam logic [5:0] OpSw   = 6'h2B;
   localparam logic [5:0] OpBeq  = 6'h04;
   localparam logic [5:0] OpBne  = 6'h05;
   localparam logic [5:0] OpAddi = 6'h08;
   localparam logic [5:0] OpJ    = 6'h02;

   localparam logic [5:0] FnAdd = 6'h20;
   localparam logic [5:0] FnSub = 6'h22;
   localparam logic [5:0] FnAnd = 6'h24;
   localparam logic [5:0] FnOr  = 6'h25;
   localparam logic [5:0] FnSlt = 6'h2A;

   typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

   state_e            state_q;
   logic [PC_W-1:0]   pc_q;
   logic [31:0]       ir_q, a_q, b_q, alu_q, mdr_q;
   logic [31:0]       rf_q [32];

   logic [5:0]        opcode, funct;
   logic [4:0]        rs, rt, rd, wb_addr;
   logic              is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_j;
   logic              funct_ok, op_legal, take_branch;
   logic [31:0]       imm_sext, alu_res, wb_data;
   logic [PC_W-1:0]   pc_plus1, br_off, br_target, jump_target;
   logic              unused_shamt;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign unused_shamt = ^ir_q[10:6];

   assign is_r    = (opcode == OpR);
   assign is_lw   = (opcode == OpLw);
   assign is_sw   = (opcode == OpSw);
   assign is_beq  = (opcode == OpBeq);
   assign is_bne  = (opcode == OpBne);
   assign is_addi = (opcode == OpAddi);
   assign is_j    = (opcode == OpJ);

   assign funct_ok = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                     (funct == FnOr)  || (funct == FnSlt);
   assign op_legal = is_lw || is_sw || is_beq || is_bne || is_addi || is_j || (is_r && funct_ok);

   assign imm_sext    = {{16{ir_q[15]}}, ir_q[15:0]};
   assign pc_plus1    = pc_q + PC_W'(1);
   assign br_off      = PC_W'($signed(ir_q[15:0]));
   assign br_target   = pc_plus1 + br_off;
   assign take_branch = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));

   // Jump keeps the upper PC bits of the sequential successor, as in MIPS j.
   if (PC_W > 26) begin : g_jump_wide
      assign jump_target = {pc_plus1[PC_W-1:26], ir_q[25:0]};
   end else begin : g_jump_narrow
      assign jump_target = ir_q[PC_W-1:0];
   end

   always_comb begin
      alu_res = a_q + imm_sext;
      if (is_r) begin
         case (funct)
            FnAdd:   alu_res = a_q + b_q;
            FnSub:   alu_res = a_q - b_q;
            FnAnd:   alu_res = a_q & b_q;
            FnOr:    alu_res = a_q | b_q;
            FnSlt:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
            default: alu_res = '0;
         endcase
      end
   end

   assign wb_addr = is_r ? rd : rt;
   assign wb_data = is_lw ? mdr_q : alu_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         pc_q    <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         unique case (state_q)
            StFetch: begin
               if (imem_ack) begin
                  ir_q    <= imem_rdata;
                  state_q <= StDecode;
               end
            end
            StDecode: begin
               a_q     <= rf_q[rs];
               b_q     <= rf_q[rt];
               state_q <= op_legal ? StExec : StHalt;
            end
            StExec: begin
               alu_q <= alu_res;
               if (is_beq || is_bne) begin
                  pc_q    <= take_branch ? br_target : pc_plus1;
                  state_q <= StFetch;
               end else if (is_j) begin
                  pc_q    <= jump_target;
                  state_q <= StFetch;
               end else if (is_lw || is_sw) begin
                  state_q <= StMem;
               end else begin
                  state_q <= StWb;
               end
            end
            StMem: begin
               if (dmem_ack) begin
                  if (is_sw) begin
                     pc_q    <= pc_plus1;
                     state_q <= StFetch;
                  end else begin
                     mdr_q   <= dmem_rdata;
                     state_q <= StWb;
                  end
               end
            end
            StWb: begin
               // r0 is never written so it keeps reading zero.
               if (wb_addr != 5'd0) rf_q[wb_addr] <= wb_data;
               pc_q    <= pc_plus1;
               state_q <= StFetch;
            end
            StHalt: begin
            end
            default: state_q <= StHalt;
         endcase
      end
   end

   assign pc         = pc_q;
   assign imem_req   = (state_q == StFetch);
   assign imem_addr  = pc_q[IMEM_AW-1:0];
   assign dmem_req   = (state_q == StMem);
   assign dmem_we    = (state_q == StMem) && is_sw;
   assign dmem_addr  = alu_q[DMEM_AW-1:0];
   assign dmem_wdata = b_q;
   assign halted     = (state_q == StHalt);
   assign retire     = ((state_q == StExec) && (is_beq || is_bne || is_j)) ||
                       ((state_q == StMem) && is_sw && dmem_ack) ||
                       (state_q == StWb);

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small programs in a bench-owned instruction memory,
// stores captured into a log and compared against hand-computed addresses and data.
module tb_multicycle_core;

   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
   logic [7:0]  imem_addr, dmem_addr;
   logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, pc;

   logic [31:0] imem [256];
   logic [31:0] dinit [256];
   int          dmem_lat  = 0;
   logic        dmem_spur = 1'b0;
   logic        imem_hold = 1'b0;
   int          dcnt;

   int          retire_n = 0, we_n = 0, fetch_n = 0, ovl_n = 0, st_n = 0;
   logic [31:0] st_addr [32];
   logic [31:0] st_data [32];

   int          n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   multicycle_core dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .pc         (pc),
      .retire     (retire),
      .halted     (halted)
   );

   assign imem_ack   = imem_req & ~imem_hold;
   assign imem_rdata = imem[imem_addr];
   assign dmem_ack   = dmem_spur | (dmem_req & (dcnt >= dmem_lat));
   assign dmem_rdata = dinit[dmem_addr];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) dcnt <= 0;
      else if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
      else dcnt <= 0;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (retire) retire_n <= retire_n + 1;
         if (dmem_req && dmem_we) we_n <= we_n + 1;
         if (imem_req) fetch_n <= fetch_n + 1;
         if (imem_req && dmem_req) ovl_n <= ovl_n + 1;
      end
   end

   always @(posedge clk) begin
      if (rst_n && dmem_req && dmem_we && dmem_ack && st_n < 32) begin
         st_addr[st_n[4:0]] <= 32'(dmem_addr);
         st_data[st_n[4:0]] <= dmem_wdata;
         st_n <= st_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                         input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                         input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(input int tgt);
      return {6'h02, 26'(tgt)};
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) imem[i[7:0]] = 32'hFC00_0000;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_stores(input int base, input int n, input string tag);
      int k = 0;
      while (st_n < base + n && k < 300) begin
         cycles(1);
         k++;
      end
      check(tag, 32'(st_n - base), 32'(n));
   endtask

   int          r0, s0, w0, f0;
   logic [4:0]  idx;
   logic [31:0] exp_addr [6];
   logic [31:0] exp_data [6];

   initial begin
      rst_n = 1'b0;
      clear_prog();
      for (int i = 0; i < 256; i++) dinit[i[7:0]] = 32'h0;
      dinit[0] = 32'hDEAD_BEEF;

      // Reset values, with clock running under reset
      #3;
      check("rst_pc", pc, 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      check("rst_retire", 32'(retire), 32'h0);
      check("rst_dmem_req", 32'(dmem_req), 32'h0);
      check("rst_dmem_we", 32'(dmem_we), 32'h0);
      cycles(3);
      check("rst_pc_clocked", pc, 32'h0);

      // addi/addi/add program, first with fetch stalled
      imem[0] = enc_i(OP_ADDI, 0, 1, 5);
      imem[1] = enc_i(OP_ADDI, 0, 2, -3);
      imem[2] = enc_r(1, 2, 3, FN_ADD);
      imem[3] = enc_i(OP_SW, 0, 3, 16);
      imem[4] = enc_j(4);
      imem_hold = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("first_cycle_imem_req", 32'(imem_req), 32'h1);
      r0 = retire_n;
      cycles(5);
      check("stall_pc", pc, 32'h0);
      check("stall_retire", 32'(retire_n - r0), 32'h0);
      check("stall_imem_req", 32'(imem_req), 32'h1);

      hold_reset();
      imem_hold = 1'b0;
      dmem_spur = 1'b1;
      s0 = st_n;
      r0 = retire_n;
      rst_n = 1'b1;
      cycles(12);
      check("add_pc_c12", pc, 32'h3);
      check("add_retires_c12", 32'(retire_n - r0), 32'h3);
      wait_stores(s0, 1, "add_store_cnt");
      idx = 5'(s0);
      check("add_r3_addr", st_addr[idx], 32'd16);
      check("add_r3_data", st_data[idx], 32'd2);

      // lw then sw with 3-cycle data ack delay
      hold_reset();
      dmem_spur = 1'b0;
      dmem_lat  = 3;
      clear_prog();
      imem[0] = enc_i(OP_LW, 0, 1, 0);
      imem[1] = enc_i(OP_SW, 0, 1, 4);
      imem[2] = enc_j(2);
      s0 = st_n;
      r0 = retire_n;
      w0 = we_n;
      rst_n = 1'b1;
      wait_stores(s0, 1, "sw_store_cnt");
      idx = 5'(s0);
      check("sw_addr", st_addr[idx], 32'd4);
      check("sw_wdata", st_data[idx], 32'hDEAD_BEEF);
      check("sw_req_cycles", 32'(we_n - w0), 32'd4);
      check("sw_retires", 32'(retire_n - r0), 32'd2);
      check("sw_req_dropped", 32'(dmem_req), 32'h0);

      // beq r0,r0,-1 loop at pc=7
      hold_reset();
      dmem_lat = 0;
      clear_prog();
      imem[0] = enc_j(7);
      imem[7] = enc_i(OP_BEQ, 0, 0, -1);
      r0 = retire_n;
      rst_n = 1'b1;
      cycles(3);
      check("j_pc", pc, 32'd7);
      cycles(3);
      check("beq_pc_1", pc, 32'd7);
      cycles(3);
      check("beq_pc_2", pc, 32'd7);
      check("beq_retires", 32'(retire_n - r0), 32'd3);

      hold_reset();
      clear_prog();
      imem[0] = enc_j(7);
      imem[7] = enc_i(OP_BNE, 0, 0, -1);
      imem[8] = enc_j(8);
      rst_n = 1'b1;
      cycles(6);
      check("bne_pc", pc, 32'd8);

      // ALU ops, r0 write, signed slt
      hold_reset();
      clear_prog();
      imem[0]  = enc_i(OP_ADDI, 0, 5, -1);
      imem[1]  = enc_i(OP_ADDI, 0, 6, 1);
      imem[2]  = enc_r(5, 6, 4, FN_SLT);
      imem[3]  = enc_i(OP_SW, 0, 4, 8);
      imem[4]  = enc_r(0, 0, 4, FN_SUB);
      imem[5]  = enc_i(OP_SW, 0, 4, 12);
      imem[6]  = enc_i(OP_ADDI, 0, 0, 7);
      imem[7]  = enc_i(OP_SW, 0, 0, 20);
      imem[8]  = enc_r(5, 6, 7, FN_OR);
      imem[9]  = enc_i(OP_SW, 0, 7, 24);
      imem[10] = enc_r(5, 6, 8, FN_AND);
      imem[11] = enc_i(OP_SW, 0, 8, 28);
      imem[12] = enc_r(6, 5, 10, FN_SLT);
      imem[13] = enc_i(OP_SW, 0, 10, 32);
      imem[14] = enc_j(14);
      exp_addr[0] = 32'd8;  exp_data[0] = 32'h1;
      exp_addr[1] = 32'd12; exp_data[1] = 32'h0;
      exp_addr[2] = 32'd20; exp_data[2] = 32'h0;
      exp_addr[3] = 32'd24; exp_data[3] = 32'hFFFF_FFFF;
      exp_addr[4] = 32'd28; exp_data[4] = 32'h1;
      exp_addr[5] = 32'd32; exp_data[5] = 32'h0;
      s0 = st_n;
      rst_n = 1'b1;
      wait_stores(s0, 6, "alu_store_cnt");
      for (int i = 0; i < 6; i++) begin
         idx = 5'(s0 + i);
         check($sformatf("alu_addr_%0d", i), st_addr[idx], exp_addr[i]);
         check($sformatf("alu_data_%0d", i), st_data[idx], exp_data[i]);
      end

      // Illegal opcode at pc=2 halts for good
      hold_reset();
      clear_prog();
      imem[0] = enc_j(2);
      imem[2] = 32'hFC00_0000;
      rst_n = 1'b1;
      cycles(4);
      check("halt_not_before_decode", 32'(halted), 32'h0);
      cycles(1);
      check("halt_after_decode", 32'(halted), 32'h1);
      check("halt_pc", pc, 32'd2);
      check("halt_imem_req", 32'(imem_req), 32'h0);
      f0 = fetch_n;
      r0 = retire_n;
      cycles(10);
      check("halt_no_fetch", 32'(fetch_n - f0), 32'h0);
      check("halt_no_retire", 32'(retire_n - r0), 32'h0);
      check("halt_pc_held", pc, 32'd2);
      check("halt_sticky", 32'(halted), 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("halt_rst_pc", pc, 32'h0);
      check("halt_rst_halted", 32'(halted), 32'h0);

      // Illegal R-type funct halts at decode
      clear_prog();
      imem[0] = enc_r(1, 2, 3, 6'h21);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cycles(2);
      check("bad_funct_halted", 32'(halted), 32'h1);
      check("bad_funct_pc", pc, 32'h0);

      // Reset during a stalled lw: request drops at once, r3 not loaded
      hold_reset();
      dmem_lat = 10;
      clear_prog();
      imem[0] = enc_i(OP_LW, 0, 3, 0);
      imem[1] = enc_i(OP_SW, 0, 3, 36);
      imem[2] = enc_j(2);
      rst_n = 1'b1;
      cycles(5);
      check("lw_waiting", 32'(dmem_req), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("lw_abort_req", 32'(dmem_req), 32'h0);
      check("lw_abort_pc", pc, 32'h0);
      clear_prog();
      imem[0] = enc_i(OP_SW, 0, 3, 36);
      imem[1] = enc_j(1);
      dmem_lat = 0;
      s0 = st_n;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("restart_imem_req", 32'(imem_req), 32'h1);
      check("restart_imem_addr", 32'(imem_addr), 32'h0);
      wait_stores(s0, 1, "restart_store_cnt");
      idx = 5'(s0);
      check("restart_addr", st_addr[idx], 32'd36);
      check("restart_r3", st_data[idx], 32'h0);

      check("req_overlap", 32'(ovl_n), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, meaning program-counter width in words.
REQ-002 The block SHALL have parameter IMEM_AW, default 8, meaning instruction-memory address width (imem_addr = pc[IMEM_AW-1:0]).
REQ-003 The block SHALL have parameter DMEM_AW, default 8, meaning data-memory address width (dmem_addr = alu_out[DMEM_AW-1:0]).
REQ-004 The block SHALL have these ports:
  - clk  in  1  clock, all state changes on rising edge.
  - rst_n  in  1  reset, asynchronous, active-low.
  - imem_req  out  1  instruction fetch request.
  - imem_addr  out  IMEM_AW  fetch word address.
  - imem_ack  in  1  fetch data valid.
  - imem_rdata  in  32  instruction word.
  - dmem_req  out  1  data access request.
  - dmem_we  out  1  1 = store, 0 = load.
  - dmem_addr  out  DMEM_AW  data word address.
  - dmem_wdata  out  32  store data.
  - dmem_ack  in  1  access complete / load data valid.
  - dmem_rdata  in  32  load data.
  - pc  out  PC_W  current PC.
  - retire  out  1  one-cycle pulse per completed instruction.
  - halted  out  1  core stopped on illegal opcode.

Function
REQ-005 The block SHALL hold an internal 32x32 register file with r0 reading 0 and ignoring writes.
REQ-006 The block SHALL implement the FSM states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-007 FETCH: imem_req SHALL be 1 and imem_addr stable until imem_ack; on ack, IR <= imem_rdata and the next state SHALL be DECODE; with no ack, the FSM stays in FETCH indefinitely.
REQ-008 DECODE: A <= rf[IR[25:21]], B <= rf[IR[20:16]]; opcode decode as follows:
  - 0x00 R-type.
  - 0x23 lw.
  - 0x2B sw.
  - 0x04 beq.
  - 0x05 bne.
  - 0x08 addi.
  - 0x02 j.
  - Any other opcode SHALL go to HALT.
REQ-009 R-type funct SHALL be decoded as follows:
  - 0x20 add.
  - 0x22 sub.
  - 0x24 and.
  - 0x25 or.
  - 0x2A slt (signed).
  - Any other funct SHALL go to HALT.
REQ-010 EXEC SHALL compute alu_out from A and B (R-type) or from A and sign-extended IR[15:0] (lw, sw, addi); arithmetic SHALL be modulo 2^32 with no overflow trap.
REQ-011 beq/bne SHALL resolve in EXEC: if taken, pc <= pc+1+sext(imm) truncated to PC_W, else pc <= pc+1; the next state SHALL be FETCH.
REQ-012 j SHALL resolve in EXEC: pc <= {pc_plus1[PC_W-1:26], IR[25:0]} when PC_W>26, else IR[PC_W-1:0]; the next state SHALL be FETCH.
REQ-013 MEM (lw/sw only): dmem_req SHALL be 1 and dmem_addr/dmem_we/dmem_wdata (=B) stable until dmem_ack.
  - sw: retires on ack and goes to FETCH.
  - lw: MDR <= dmem_rdata and goes to WB.
REQ-014 WB SHALL write rf[rd] (R-type), rf[rt] (addi: alu_out; lw: MDR).
REQ-015 Non-branch instructions SHALL update pc <= pc+1 in their final state; PC wrap from all-ones to 0 SHALL be silent.
REQ-016 retire SHALL pulse exactly once in the final cycle of each completed instruction, never in HALT.
REQ-017 Latency in cycles with zero-wait memories (ack in the same cycle as req) SHALL be:
  - beq/bne/j: 3.
  - sw: 4.
  - R-type/addi: 4 (FETCH, DECODE, EXEC, WB).
  - lw: 5.
REQ-018 HALT SHALL be terminal: halted=1, all requests 0, no state updates until reset.
REQ-019 imem_req and dmem_req SHALL never be asserted together.
REQ-020 An ack arriving when the corresponding req is 0 SHALL be ignored.

Reset
REQ-021 While rst_n=0, regardless of clock, the following SHALL hold:
  - pc=0.
  - state=FETCH.
  - IR, A, B, alu_out and MDR = 0.
  - All registers = 0.
  - retire=0, halted=0.
  - dmem_req=0, dmem_we=0.
REQ-022 imem_req SHALL be 1 in the first cycle after rst_n rises.
REQ-023 Reset asserted mid-access SHALL abort the access; any outstanding ack after reset release SHALL be treated per REQ-020 only if imem_req is low, otherwise accepted as the fetch of address 0.

Verification
REQ-024 addi r1,r0,5 then addi r2,r0,-3 then add r3,r1,r2, zero-wait -> r3=2, three retire pulses, pc=3 after cycle 12.
REQ-025 sw r1,4(r0) with r1=0xDEADBEEF, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, addr=4, wdata=0xDEADBEEF, we=1, single retire.
REQ-026 beq r0,r0,-1 at pc=7 -> pc returns to 7 every 3 cycles; bne r0,r0,-1 -> pc=8.
REQ-027 slt r4,r5,r6 with r5=0xFFFFFFFF, r6=1 -> r4=1; sub r4,r0,r0 -> r4=0; write to r0 -> r0 still reads 0.
REQ-028 Opcode 0x3F fetched at pc=2 -> halted=1 after DECODE, pc stays 2, no further imem_req; rst_n pulse low -> pc=0, halted=0.
REQ-029 rst_n asserted during lw MEM wait -> dmem_req drops immediately (asynchronously), target register unchanged, fetch restarts at 0.
